// File: rtl/agc_mon_injector_if.sv
// Host-side request/completion bundle for the AGC monitor-data injector.
// Host raises inj_valid with inj_data/inj_tp; the block answers with inj_done/inj_status.
// Transfer occurs on the clock where inj_valid and inj_ready are both high.
interface agc_mon_injector_if;
    logic        inj_valid;
    logic        inj_ready;
    logic [15:0] inj_data;
    logic [3:0]  inj_tp;
    logic        inj_done;
    logic [1:0]  inj_status;

    modport master (
        output inj_valid, inj_data, inj_tp,
        input  inj_ready, inj_done, inj_status
    );

    modport slave (
        input  inj_valid, inj_data, inj_tp,
        output inj_ready, inj_done, inj_status
    );
endinterface

// File: rtl/agc_mon_injector.sv
// Purpose: monitor AGC timepulses and drive one 16-bit MDT word inside a chosen timepulse.
// Latency: SYNC_STAGES+1 cycles from raw MT edge to FSM reaction; MDT follows one cycle later.
// Backpressure: inj_ready is high only in IDLE; one request is in flight at a time.
module agc_mon_injector #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST_n,
    input  logic               MT01, MT02, MT03, MT04, MT05, MT06,
    input  logic               MT07, MT08, MT09, MT10, MT11, MT12,
    input  logic               MGOJAM,
    agc_mon_injector_if.slave  inj,
    input  logic               err_clr,
    output logic               MDT01, MDT02, MDT03, MDT04, MDT05, MDT06, MDT07, MDT08,
    output logic               MDT09, MDT10, MDT11, MDT12, MDT13, MDT14, MDT15, MDT16,
    output logic [3:0]         tp_index,
    output logic [15:0]        mct_count,
    output logic               seq_err,
    output logic               onehot_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_GOJAM = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_BADTP = 2'b11;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_TP, DRIVE, DONE} state_t;

    // Index (1..12) of the lowest set bit, 0 when none is set.
    function automatic logic [3:0] enc12(input logic [11:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) r = 4'(i + 1);
        end
        return r;
    endfunction

    // Bit 12 carries MGOJAM alongside the twelve timepulses.
    logic [12:0]                  raw_in;
    logic [SYNC_STAGES-1:0][12:0] sync_q;
    logic [12:0]                  prev_q;
    logic [11:0]                  mt_cur, mt_rise, mt_fall;
    logic                         gj_rise, any_rise, multi_hot;
    logic [3:0]                   cur_idx, rise_idx, last_q, exp_idx;
    logic                         armed_q, seq_ev;

    assign raw_in = {MGOJAM, MT12, MT11, MT10, MT09, MT08, MT07,
                     MT06, MT05, MT04, MT03, MT02, MT01};

    assign mt_cur    = sync_q[SYNC_STAGES-1][11:0];
    assign mt_rise   = mt_cur & ~prev_q[11:0];
    assign mt_fall   = ~mt_cur & prev_q[11:0];
    assign gj_rise   = sync_q[SYNC_STAGES-1][12] & ~prev_q[12];
    assign any_rise  = |mt_rise;
    assign multi_hot = ($countones(mt_cur) > 1);
    assign cur_idx   = enc12(mt_cur);
    assign rise_idx  = enc12(mt_rise);
    assign exp_idx   = (last_q == 4'd12) ? 4'd1 : last_q + 4'd1;
    // Sequence check is skipped on the first rise after reset or MGOJAM.
    assign seq_ev    = any_rise && armed_q && !gj_rise && (rise_idx != exp_idx);

    // Synchronizer chain plus one edge-detect register per line.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Timepulse index, memory-cycle counter and sticky protocol errors.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            tp_index   <= 4'd0;
            mct_count  <= 16'd0;
            last_q     <= 4'd0;
            armed_q    <= 1'b0;
            seq_err    <= 1'b0;
            onehot_err <= 1'b0;
        end else begin
            if (mt_cur == 12'd0)  tp_index <= 4'd0;
            else if (!multi_hot)  tp_index <= cur_idx;

            if (gj_rise)          mct_count <= 16'd0;
            else if (mt_rise[0])  mct_count <= mct_count + 16'd1;

            if (gj_rise) begin
                armed_q <= 1'b0;
            end else if (any_rise) begin
                armed_q <= 1'b1;
                last_q  <= rise_idx;
            end

            // A new error event outranks a simultaneous clear.
            seq_err    <= seq_ev    | (seq_err    & ~err_clr);
            onehot_err <= multi_hot | (onehot_err & ~err_clr);
        end
    end

    state_t            state_q, state_d;
    logic [1:0]        status_q, status_d;
    logic [15:0]       data_q, mdt_q;
    logic [11:0]       tp_mask_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              rdy_en_q;
    logic              xfer, tp_bad, waiting, tmo_hit, tp_rise, tp_fall;

    assign inj.inj_ready  = (state_q == IDLE) && rdy_en_q;
    assign inj.inj_done   = (state_q == DONE);
    assign inj.inj_status = status_q;

    assign xfer    = inj.inj_valid && inj.inj_ready;
    assign tp_bad  = (inj.inj_tp == 4'd0) || (inj.inj_tp > 4'd12);
    assign waiting = (state_q == ARM) || (state_q == WAIT_TP);
    assign tmo_hit = waiting && !any_rise && (tmo_q == TMO_LAST);
    assign tp_rise = |(mt_rise & tp_mask_q);
    assign tp_fall = |(mt_fall & tp_mask_q);

    assign {MDT16, MDT15, MDT14, MDT13, MDT12, MDT11, MDT10, MDT09,
            MDT08, MDT07, MDT06, MDT05, MDT04, MDT03, MDT02, MDT01} = mdt_q;

    // Request FSM next-state and completion status; MGOJAM abort has top priority.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (tp_bad) begin
                        state_d  = DONE;
                        status_d = ST_BADTP;
                    end else begin
                        state_d  = ARM;
                    end
                end
            end
            ARM: begin
                if (gj_rise) begin
                    state_d  = DONE;
                    status_d = ST_GOJAM;
                end else if (mt_rise[0]) begin
                    state_d  = tp_mask_q[0] ? DRIVE : WAIT_TP;
                end else if (tmo_hit) begin
                    state_d  = DONE;
                    status_d = ST_TMO;
                end
            end
            WAIT_TP: begin
                if (gj_rise) begin
                    state_d  = DONE;
                    status_d = ST_GOJAM;
                end else if (tp_rise) begin
                    state_d  = DRIVE;
                end else if (tmo_hit) begin
                    state_d  = DONE;
                    status_d = ST_TMO;
                end
            end
            DRIVE: begin
                if (gj_rise) begin
                    state_d  = DONE;
                    status_d = ST_GOJAM;
                end else if (tp_fall) begin
                    state_d  = DONE;
                    status_d = ST_OK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, request capture, timeout counter and registered MDT drive.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state_q   <= IDLE;
            status_q  <= ST_OK;
            data_q    <= 16'd0;
            tp_mask_q <= 12'd0;
            tmo_q     <= '0;
            rdy_en_q  <= 1'b0;
            mdt_q     <= 16'd0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            rdy_en_q <= 1'b1;
            if (xfer) begin
                data_q    <= inj.inj_data;
                tp_mask_q <= 12'(1) << (inj.inj_tp - 4'd1);
            end
            tmo_q <= (waiting && !any_rise) ? tmo_q + TMO_W'(1) : '0;
            // Drops to zero on the same edge that leaves DRIVE.
            mdt_q <= (state_q == DRIVE && state_d == DRIVE) ? data_q : 16'd0;
        end
    end

endmodule
